// File: rtl/exec_stage_pkg.sv
// Shared constants and types for the execute stage and the ALU control decoder.
package exec_stage_pkg;

   // ALU operation selects; 6 and 7 are reserved and produce 0.
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_SLT = 3'd4;
   localparam logic [2:0] ALU_XOR = 3'd5;

   // Control bits that ride through EX into MEM/WB untouched.
   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
   } ctrl_t;

endpackage

// File: rtl/exec_stage_alu.sv
// Combinational ALU: ADD/SUB modulo 2^WIDTH, bitwise AND/OR/XOR, signed SLT.
module alu_core
   import exec_stage_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       sel,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   // Operation select; reserved codes fall through to 0.
   always_comb begin
      result = '0;
      case (sel)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_XOR: result = a ^ b;
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/exec_stage.sv
// Execute stage: operand mux, ALU, branch resolution and the EX/MEM register.
module exec_stage
   import exec_stage_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              stall,
   input  logic              flush,
   input  logic [2:0]        alu_sel,
   input  logic              alu_src,
   input  logic [WIDTH-1:0]  rd_a,
   input  logic [WIDTH-1:0]  rd_b,
   input  logic [WIDTH-1:0]  imm,
   input  logic [WIDTH-1:0]  pc_plus4,
   input  logic              branch,
   input  logic              reg_write,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              mem_to_reg,
   input  logic [REG_AW-1:0] write_reg,
   output logic              out_valid,
   output logic [WIDTH-1:0]  alu_result,
   output logic              zero,
   output logic [WIDTH-1:0]  store_data,
   output logic              branch_taken,
   output logic [WIDTH-1:0]  branch_target,
   output logic              reg_write_o,
   output logic              mem_read_o,
   output logic              mem_write_o,
   output logic              mem_to_reg_o,
   output logic [REG_AW-1:0] write_reg_o
);

   // EX/MEM payload; the valid bit is kept separately.
   typedef struct packed {
      logic [WIDTH-1:0]  alu_result;
      logic              zero;
      logic [WIDTH-1:0]  store_data;
      logic              branch_taken;
      logic [WIDTH-1:0]  branch_target;
      ctrl_t             ctrl;
      logic [REG_AW-1:0] write_reg;
   } exmem_t;

   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] alu_res;
   logic             alu_zero;
   exmem_t           nxt;
   exmem_t           q;
   logic             valid_q;

   assign op_b = alu_src ? imm : rd_b;

   alu_core #(.WIDTH(WIDTH)) u_alu (
      .a      (rd_a),
      .b      (op_b),
      .sel    (alu_sel),
      .result (alu_res),
      .zero   (alu_zero)
   );

   // Assemble the payload a valid instruction would load.
   always_comb begin
      nxt                = '0;
      nxt.alu_result     = alu_res;
      nxt.zero           = alu_zero;
      nxt.store_data     = rd_b;
      nxt.branch_taken   = branch & alu_zero;
      nxt.branch_target  = pc_plus4 + {imm[WIDTH-3:0], 2'b00};
      nxt.ctrl.reg_write  = reg_write;
      nxt.ctrl.mem_read   = mem_read;
      nxt.ctrl.mem_write  = mem_write;
      nxt.ctrl.mem_to_reg = mem_to_reg;
      nxt.write_reg      = write_reg;
   end

   // EX/MEM register: reset > flush > stall (hold) > load; invalid loads become bubbles.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         q       <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
         q       <= '0;
      end else if (!stall) begin
         valid_q <= in_valid;
         q       <= in_valid ? nxt : '0;
      end
   end

   assign out_valid     = valid_q;
   assign alu_result    = q.alu_result;
   assign zero          = q.zero;
   assign store_data    = q.store_data;
   assign branch_taken  = q.branch_taken;
   assign branch_target = q.branch_target;
   assign reg_write_o   = q.ctrl.reg_write;
   assign mem_read_o    = q.ctrl.mem_read;
   assign mem_write_o   = q.ctrl.mem_write;
   assign mem_to_reg_o  = q.ctrl.mem_to_reg;
   assign write_reg_o   = q.write_reg;

endmodule
